ysyx_exu_rsv: RTL

YSYX_EXU_RSV -- requirements
Module: ysyx_exu_rsv

---
 rtl/ysyx_exu_rsv_pkg.sv | 16 +
 rtl/ysyx_exu_rsv_pick.sv | 32 +++
 rtl/ysyx_exu_rsv.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_exu_rsv_pkg.sv
// Shared ysyx constants for the execute-stage reservation station:
// default sizes, ROB tag width derivation and the "operand ready" tag value.
package ysyx_exu_rsv_pkg;

  localparam int YSYX_RS_SIZE  = 4;
  localparam int YSYX_ROB_SIZE = 8;
  localparam int TAG_READY     = 0;

  // One extra bit beyond the ROB index so that tag 0 can mean "no producer".
  function automatic int tag_w(input int rob_size);
    return $clog2(rob_size) + 1;
  endfunction

  localparam int YSYX_TAG_W = tag_w(YSYX_ROB_SIZE);

endpackage

// File: rtl/ysyx_exu_rsv_pick.sv
// Oldest-ready selector: age matrix plus eligibility mask to one-hot grant and index.
// i_age bit (i*N + j) set means entry i is older than entry j.
module ysyx_exu_rsv_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N*N-1:0]   i_age,
  input  logic [N-1:0]     i_elig,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // An eligible entry wins when no other eligible entry is older than it.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = i_elig[i];
      for (int j = 0; j < N; j++)
        if (j != i && i_elig[j] && i_age[j*N + i]) o_grant[i] = 1'b0;
    end
  end

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++)
      if (o_grant[i]) o_idx = i[IDX_W-1:0];
  end

  assign o_valid = |o_grant;

endmodule

// File: rtl/ysyx_exu_rsv.sv
// Execute-unit reservation station: operand capture from CDB broadcasts,
// oldest-ready issue through an age matrix, single enqueue/issue per cycle.
module ysyx_exu_rsv
  import ysyx_exu_rsv_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int RS_SIZE   = YSYX_RS_SIZE,
  parameter  int ROB_SIZE  = YSYX_ROB_SIZE,
  parameter  int NCDB      = 2,
  parameter  int PAYLOAD_W = 96,
  localparam int TAG_W     = tag_w(ROB_SIZE),
  localparam int IDX_W     = $clog2(RS_SIZE),
  localparam int CNT_W     = $clog2(RS_SIZE) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_vj,
  input  logic [XLEN-1:0]       in_vk,
  input  logic [TAG_W-1:0]      in_qj,
  input  logic [TAG_W-1:0]      in_qk,
  input  logic [TAG_W-1:0]      in_dest,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*TAG_W-1:0] cdb_tag,
  input  logic [NCDB*XLEN-1:0]  cdb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_vj,
  output logic [XLEN-1:0]       out_vk,
  output logic [TAG_W-1:0]      out_dest,
  output logic [PAYLOAD_W-1:0]  out_payload,
  output logic [CNT_W-1:0]      out_count
);

  logic [RS_SIZE-1:0]         r_busy;
  logic [RS_SIZE*RS_SIZE-1:0] r_age;
  logic [XLEN-1:0]            r_vj      [RS_SIZE];
  logic [XLEN-1:0]            r_vk      [RS_SIZE];
  logic [TAG_W-1:0]           r_qj      [RS_SIZE];
  logic [TAG_W-1:0]           r_qk      [RS_SIZE];
  logic [TAG_W-1:0]           r_dest    [RS_SIZE];
  logic [PAYLOAD_W-1:0]       r_payload [RS_SIZE];

  logic [RS_SIZE-1:0] w_elig, w_grant, w_free_oh;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_sel_vld, w_enq, w_issue;
  logic [XLEN-1:0]    w_enq_vj, w_enq_vk;
  logic [TAG_W-1:0]   w_enq_qj, w_enq_qk;
  logic [XLEN-1:0]    w_nxt_vj [RS_SIZE];
  logic [XLEN-1:0]    w_nxt_vk [RS_SIZE];
  logic [TAG_W-1:0]   w_nxt_qj [RS_SIZE];
  logic [TAG_W-1:0]   w_nxt_qk [RS_SIZE];
  logic [CNT_W-1:0]   w_count;

  // Snoop all CDB channels for a pending tag; descending scan lets channel 0 win.
  function automatic logic [TAG_W+XLEN-1:0] snoop(
    input logic [TAG_W-1:0]      q,
    input logic [XLEN-1:0]       v,
    input logic [NCDB-1:0]       cv,
    input logic [NCDB*TAG_W-1:0] ct,
    input logic [NCDB*XLEN-1:0]  cd
  );
    logic [TAG_W+XLEN-1:0] res;
    res = {q, v};
    if (q != TAG_W'(TAG_READY))
      for (int c = NCDB-1; c >= 0; c--)
        if (cv[c] && ct[c*TAG_W +: TAG_W] == q)
          res = {TAG_W'(TAG_READY), cd[c*XLEN +: XLEN]};
    return res;
  endfunction

  always_comb begin
    {w_enq_qj, w_enq_vj} = snoop(in_qj, in_vj, cdb_valid, cdb_tag, cdb_data);
    {w_enq_qk, w_enq_vk} = snoop(in_qk, in_vk, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_nxt_vj[i] = r_vj[i];
      w_nxt_qj[i] = r_qj[i];
      w_nxt_vk[i] = r_vk[i];
      w_nxt_qk[i] = r_qk[i];
      if (r_busy[i]) begin
        {w_nxt_qj[i], w_nxt_vj[i]} = snoop(r_qj[i], r_vj[i], cdb_valid, cdb_tag, cdb_data);
        {w_nxt_qk[i], w_nxt_vk[i]} = snoop(r_qk[i], r_vk[i], cdb_valid, cdb_tag, cdb_data);
      end
    end
  end

  always_comb begin
    w_free_oh = '0;
    for (int i = RS_SIZE-1; i >= 0; i--)
      if (!r_busy[i]) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
      end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_elig[i] = r_busy[i] && r_qj[i] == TAG_W'(TAG_READY) && r_qk[i] == TAG_W'(TAG_READY);
      w_count   = w_count + CNT_W'(r_busy[i]);
    end
  end

  ysyx_exu_rsv_pick #(.N(RS_SIZE)) u_pick (
    .i_age   (r_age),
    .i_elig  (w_elig),
    .o_grant (w_grant),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_vld)
  );

  // Handshake outputs come only from registered state, so they show pre-flush values.
  assign in_ready    = ~&r_busy;
  assign out_valid   = w_sel_vld;
  assign out_vj      = w_sel_vld ? r_vj[w_sel_idx]      : '0;
  assign out_vk      = w_sel_vld ? r_vk[w_sel_idx]      : '0;
  assign out_dest    = w_sel_vld ? r_dest[w_sel_idx]    : '0;
  assign out_payload = w_sel_vld ? r_payload[w_sel_idx] : '0;
  assign out_count   = w_count;

  assign w_enq   = in_valid && in_ready && !flush;
  assign w_issue = w_sel_vld && out_ready && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
      r_age  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_vj[i]      <= '0;
        r_vk[i]      <= '0;
        r_qj[i]      <= '0;
        r_qk[i]      <= '0;
        r_dest[i]    <= '0;
        r_payload[i] <= '0;
      end
    end else if (flush) begin
      r_busy <= '0;
      r_age  <= '0;
    end else begin
      r_busy <= (r_busy & ~(w_issue ? w_grant : '0)) | (w_enq ? w_free_oh : '0);
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_enq && w_free_oh[i]) begin
          r_vj[i]      <= w_enq_vj;
          r_vk[i]      <= w_enq_vk;
          r_qj[i]      <= w_enq_qj;
          r_qk[i]      <= w_enq_qk;
          r_dest[i]    <= in_dest;
          r_payload[i] <= in_payload;
        end else begin
          r_vj[i] <= w_nxt_vj[i];
          r_vk[i] <= w_nxt_vk[i];
          r_qj[i] <= w_nxt_qj[i];
          r_qk[i] <= w_nxt_qk[i];
        end
        // New entry is younger than every currently busy entry.
        for (int j = 0; j < RS_SIZE; j++)
          if (w_enq) begin
            if (w_free_oh[i])                  r_age[i*RS_SIZE + j] <= 1'b0;
            else if (w_free_oh[j] && r_busy[i]) r_age[i*RS_SIZE + j] <= 1'b1;
          end
      end
    end
  end

endmodule
